position_subtract_seq: RTL

POSITION_SUBTRACT_SEQ -- requirements
Module: position_subtract_seq

---
 rtl/position_subtract_seq_pkg.sv | 15 +
 rtl/position_subtract_seq_sub_chunk.sv | 19 +
 rtl/position_subtract_seq.sv | 104 ++++++++++
 3 files changed

// File: rtl/position_subtract_seq_pkg.sv
// Shared types and field geometry for the chunked fixed-point position subtractor.
// The integer field sits above a 33-bit fraction inside a 65-bit position word.
package position_subtract_seq_pkg;

    localparam int POS_W     = 65;
    localparam int FIELD_LSB = 33;
    localparam int FIELD_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/position_subtract_seq_sub_chunk.sv
// One W-bit slice of a ripple subtractor: d = a - b - bin, bout set on underflow.
module sub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] full;

    // The extra top bit becomes 1 exactly when the slice result goes negative.
    assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign d    = full[W-1:0];
    assign bout = full[W];

endmodule

// File: rtl/position_subtract_seq.sv
// Subtracts B from the integer field of position A, CHUNK_W bits per cycle,
// using a single reused sub_chunk; the fraction passes through untouched.
module position_subtract_seq
    import position_subtract_seq_pkg::*;
#(
    parameter int CHUNK_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [POS_W-1:0]   A,
    input  logic [FIELD_W-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [POS_W-1:0]   R,
    output logic               borrow
);

    localparam int NCH   = FIELD_W / CHUNK_W;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

    state_t               state;
    logic [FIELD_W-1:0]   a_sh;
    logic [FIELD_W-1:0]   b_sh;
    logic [FIELD_W-1:0]   diff;
    logic [FIELD_LSB-1:0] frac;
    logic [CNT_W-1:0]     k;
    logic                 bchain;

    logic [CHUNK_W-1:0]   d_chunk;
    logic                 bout;
    logic [FIELD_W-1:0]   diff_nxt;

    sub_chunk #(.W(CHUNK_W)) u_sub (
        .a    (a_sh[CHUNK_W-1:0]),
        .b    (b_sh[CHUNK_W-1:0]),
        .bin  (bchain),
        .d    (d_chunk),
        .bout (bout)
    );

    // Operands shift down each cycle; the difference fills in from the top so
    // that after NCH cycles chunk 0 has landed in the least significant slot.
    generate
        if (CHUNK_W == FIELD_W) begin : g_one_chunk
            assign diff_nxt = d_chunk;
        end else begin : g_multi_chunk
            assign diff_nxt = {d_chunk, diff[FIELD_W-1:CHUNK_W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            R      <= '0;
            borrow <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            frac   <= '0;
            diff   <= '0;
            k      <= '0;
            bchain <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= A[POS_W-1:FIELD_LSB];
                        b_sh   <= B;
                        frac   <= A[FIELD_LSB-1:0];
                        diff   <= '0;
                        k      <= '0;
                        bchain <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    a_sh   <= a_sh >> CHUNK_W;
                    b_sh   <= b_sh >> CHUNK_W;
                    diff   <= diff_nxt;
                    bchain <= bout;
                    k      <= k + 1'b1;
                    if (k == LAST) state <= DONE;
                end
                DONE: begin
                    R      <= {diff, frac};
                    borrow <= bchain;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
